// File: rtl/cache_bus_arbiter.sv
// Two-client (I-cache / D-cache) line-fill arbiter onto a single downstream bus.
// One read transaction in flight; response beats are forwarded with one cycle of latency.
module cache_bus_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int TAGWIDTH = 13,
  parameter int BEATS    = 8
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ic_reqcyc,
  input  logic [WORDSIZE-1:0] ic_req,
  input  logic [TAGWIDTH-1:0] ic_reqtag,
  output logic                ic_reqack,
  output logic                ic_respcyc,
  output logic [WORDSIZE-1:0] ic_resp,
  output logic [TAGWIDTH-1:0] ic_resptag,
  input  logic                ic_respack,

  input  logic                dc_reqcyc,
  input  logic [WORDSIZE-1:0] dc_req,
  input  logic [TAGWIDTH-1:0] dc_reqtag,
  output logic                dc_reqack,
  output logic                dc_respcyc,
  output logic [WORDSIZE-1:0] dc_resp,
  output logic [TAGWIDTH-1:0] dc_resptag,
  input  logic                dc_respack,

  output logic                bus_reqcyc,
  output logic [WORDSIZE-1:0] bus_req,
  output logic [TAGWIDTH-1:0] bus_reqtag,
  input  logic                bus_reqack,
  input  logic                bus_respcyc,
  input  logic [WORDSIZE-1:0] bus_resp,
  input  logic [TAGWIDTH-1:0] bus_resptag,
  output logic                bus_respack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_STREAM,
    S_DONE
  } state_e;

  typedef enum logic {
    CL_IC = 1'b0,
    CL_DC = 1'b1
  } client_e;

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_e              state_q, state_d;
  client_e             grant_q, grant_d;
  client_e             last_grant_q, last_grant_d;
  logic [WORDSIZE-1:0] addr_q, addr_d;
  logic [TAGWIDTH-1:0] tag_q, tag_d;
  logic                bus_reqcyc_q, bus_reqcyc_d;
  logic                reqack_q, reqack_d;
  logic                respcyc_q, respcyc_d;
  logic [WORDSIZE-1:0] resp_q, resp_d;
  logic [TAGWIDTH-1:0] resptag_q, resptag_d;
  logic [2:0]          beat_q, beat_d;

  logic any_req;
  logic pick_dc;
  logic beat_fire;
  logic last_beat;

  // On a tie the client that was not granted last wins.
  always_comb begin
    any_req   = ic_reqcyc | dc_reqcyc;
    pick_dc   = dc_reqcyc && (!ic_reqcyc || (last_grant_q == CL_IC));
    beat_fire = bus_respcyc && ((state_q == S_GRANT) || (state_q == S_STREAM));
    last_beat = beat_fire && (beat_q == LAST_BEAT);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable driven here gets a default first; a missed branch would
    // otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_GRANT;
      S_GRANT: begin
        if (last_beat)                       state_d = S_DONE;
        else if (bus_reqack || bus_respcyc)  state_d = S_STREAM;
      end
      S_STREAM: if (last_beat) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: request capture, acceptance pulse and beat forwarding.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    tag_d        = tag_q;
    bus_reqcyc_d = bus_reqcyc_q;
    reqack_d     = 1'b0;
    respcyc_d    = 1'b0;
    resp_d       = '0;
    resptag_d    = '0;
    beat_d       = beat_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d      = pick_dc ? CL_DC : CL_IC;
          last_grant_d = pick_dc ? CL_DC : CL_IC;
          addr_d       = pick_dc ? dc_req : ic_req;
          tag_d        = pick_dc ? dc_reqtag : ic_reqtag;
          reqack_d     = 1'b1;
          bus_reqcyc_d = 1'b1;
          beat_d       = '0;
        end
      end
      S_GRANT: begin
        // An early response beat implies the bus already took the request.
        if (bus_reqack || bus_respcyc) bus_reqcyc_d = 1'b0;
      end
      S_DONE:  beat_d = '0;
      default: ;
    endcase

    if (beat_fire) begin
      respcyc_d = 1'b1;
      resp_d    = bus_resp;
      resptag_d = bus_resptag;
      beat_d    = beat_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q      <= CL_IC;
      last_grant_q <= CL_DC;
      addr_q       <= '0;
      tag_q        <= '0;
      bus_reqcyc_q <= 1'b0;
      reqack_q     <= 1'b0;
      respcyc_q    <= 1'b0;
      resp_q       <= '0;
      resptag_q    <= '0;
      beat_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
      bus_reqcyc_q <= bus_reqcyc_d;
      reqack_q     <= reqack_d;
      respcyc_q    <= respcyc_d;
      resp_q       <= resp_d;
      resptag_q    <= resptag_d;
      beat_q       <= beat_d;
    end
  end

  // Outputs: everything client-facing is steered to the granted client and zero elsewhere.
  always_comb begin
    ic_reqack   = reqack_q && (grant_q == CL_IC);
    dc_reqack   = reqack_q && (grant_q == CL_DC);
    ic_respcyc  = respcyc_q && (grant_q == CL_IC);
    dc_respcyc  = respcyc_q && (grant_q == CL_DC);
    ic_resp     = ic_respcyc ? resp_q : '0;
    dc_resp     = dc_respcyc ? resp_q : '0;
    ic_resptag  = ic_respcyc ? resptag_q : '0;
    dc_resptag  = dc_respcyc ? resptag_q : '0;
    bus_reqcyc  = bus_reqcyc_q;
    bus_req     = bus_reqcyc_q ? addr_q : '0;
    bus_reqtag  = bus_reqcyc_q ? tag_q : '0;
    bus_respack = 1'b0;
    if (state_q != S_IDLE) begin
      bus_respack = (grant_q == CL_DC) ? dc_respack : ic_respack;
    end
  end

endmodule
